// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared constants and types for the sync FIFO read-side adapter
package sync_fifo_pkg;
  localparam int FIFO_RD_LAT = 1;
  localparam int FWFT_BUF_DEPTH = 2;
  localparam int OCC_W = $clog2(FWFT_BUF_DEPTH + 1);
  typedef logic [OCC_W-1:0] occ_t;
endpackage

// File: rtl/fwft_skid_buf.sv
// fwft_skid_buf: two-entry output buffer presenting a registered valid/data stream
module fwft_skid_buf
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             m_ready,
  output logic             pop,
  output occ_t             occ,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data
);
  logic [WIDTH-1:0] mem_q [FWFT_BUF_DEPTH];
  logic [WIDTH-1:0] mem_d [FWFT_BUF_DEPTH];
  logic head_q, head_d, tail_q, tail_d;
  occ_t occ_q, occ_d;
  logic m_valid_q, m_valid_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  // next buffer state; outputs are registered copies of the next head entry
  always_comb begin
    pop = m_valid_q & m_ready;
    mem_d = mem_q;
    if (push) mem_d[tail_q] = din;
    occ_d = flush ? '0 : occ_q + occ_t'(push) - occ_t'(pop);
    head_d = ~flush & (head_q ^ pop);
    tail_d = ~flush & (tail_q ^ push);
    m_valid_d = occ_d != '0;
    m_data_d = mem_d[head_d];
  end
  // state registers; overflow is prevented by the reader's read credit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      head_q <= 1'b0;
      tail_q <= 1'b0;
      occ_q <= '0;
      m_valid_q <= 1'b0;
      m_data_q <= '0;
    end else begin
      assert (!(occ_q == occ_t'(FWFT_BUF_DEPTH) && push && !pop));
      mem_q <= mem_d;
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q <= occ_d;
      m_valid_q <= m_valid_d;
      m_data_q <= m_data_d;
    end
  end
  assign occ = occ_q;
  assign m_valid = m_valid_q;
  assign m_data = m_data_q;
endmodule

// File: rtl/sync_fifo_fwft_reader.sv
// sync_fifo_fwft_reader: FWFT valid/ready front end for sync_fifo_spram; FWFT_XFER_CNT_EN adds xfer_cnt
module sync_fifo_fwft_reader
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = 8
`ifdef FWFT_XFER_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             fifo_empty,
  output logic             fifo_rd,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
`ifdef FWFT_XFER_CNT_EN
  , output logic [CNT_W-1:0] xfer_cnt
`endif
);
  localparam int CRED_W = OCC_W + 1;
  logic [FIFO_RD_LAT-1:0] rd_pend_q, rd_pend_d;
  logic push, pop;
  occ_t occ;
  logic [CRED_W-1:0] credit;
  // issue a read only when the buffer can absorb it after this cycle's pop
  always_comb begin
    push = rd_pend_q[FIFO_RD_LAT-1] & ~flush;
    credit = CRED_W'(occ) + CRED_W'(rd_pend_q[FIFO_RD_LAT-1]) - CRED_W'(pop);
    fifo_rd = rst_n & ~flush & ~fifo_empty & (credit < CRED_W'(FWFT_BUF_DEPTH));
    rd_pend_d = FIFO_RD_LAT'(fifo_rd);
  end
  // track the read whose data returns next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_pend_q <= '0;
    else rd_pend_q <= rd_pend_d;
  end
  fwft_skid_buf #(.WIDTH(WIDTH)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .push    (push),
    .din     (fifo_dout),
    .m_ready (m_ready),
    .pop     (pop),
    .occ     (occ),
    .m_valid (m_valid),
    .m_data  (m_data)
  );
`ifdef FWFT_XFER_CNT_EN
  logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
  always_comb xfer_cnt_d = xfer_cnt_q + CNT_W'(pop);
  // count accepted beats; only reset clears it, flush does not
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) xfer_cnt_q <= '0;
    else xfer_cnt_q <= xfer_cnt_d;
  end
  assign xfer_cnt = xfer_cnt_q;
`endif
endmodule
